// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared definitions for the extended UART receiver: FSM state
//               encodings, legal oversampling ratios, data length limits.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  // Receiver FSM states, explicitly encoded
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Legal oversampling ratios (clock cycles per bit)
  localparam int c_PRESCALE_8  = 8;
  localparam int c_PRESCALE_16 = 16;
  localparam int c_PRESCALE_32 = 32;

  // Shortest frame payload accepted
  localparam int DATA_LEN_MIN = 5;

  // Force a requested data length into DATA_LEN_MIN..max_len so that a bad
  // configuration can never index past the shift register.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    logic [3:0] res;
    res = len;
    if (int'(len) < DATA_LEN_MIN) begin
      res = 4'(DATA_LEN_MIN);
    end else if (int'(len) > max_len) begin
      res = 4'(max_len);
    end
    return res;
  endfunction

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Per-bit edge counter and three-point majority vote. bit_done
//               pulses the cycle after the last sample point with the voted
//               value on sbit; bit_end marks the final cycle of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      rx_s,
  output logic                      bit_done,
  output logic                      bit_end,
  output logic                      sbit
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [PRESCALE_WIDTH-1:0] w_half;
  logic [PRESCALE_WIDTH-1:0] w_last;
  logic                      r_s0;
  logic                      r_s1;
  logic                      r_done;
  logic                      r_sbit;
  logic                      w_maj;

  assign w_half = prescale >> 1;
  assign w_last = prescale - PRESCALE_WIDTH'(1);
  assign w_maj  = (r_s0 & r_s1) | (r_s0 & rx_s) | (r_s1 & rx_s);

  // Edge counter: the start-detect cycle is count 0, so the next cycle is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= PRESCALE_WIDTH'(1);
    end else if (run) begin
      r_cnt <= (r_cnt == w_last) ? '0 : r_cnt + PRESCALE_WIDTH'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Capture the two early samples and vote with the third at Prescale/2+1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0   <= 1'b1;
      r_s1   <= 1'b1;
      r_done <= 1'b0;
      r_sbit <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (run) begin
        if (r_cnt == w_half - PRESCALE_WIDTH'(1)) begin
          r_s0 <= rx_s;
        end
        if (r_cnt == w_half) begin
          r_s1 <= rx_s;
        end
        if (r_cnt == w_half + PRESCALE_WIDTH'(1)) begin
          r_sbit <= w_maj;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bit_done = r_done;
  assign sbit     = r_sbit;
  assign bit_end  = run && (r_cnt == w_last);

endmodule : uart_rx_sampler
`default_nettype wire

// File: rtl/uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ext
// Description : Configurable UART receiver (5..DATA_WIDTH data bits, optional
//               parity, one or two stop bits, 8/16/32x oversampling) with a
//               valid/ready output register and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ext
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 9,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [3:0]                DATA_LEN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STP2,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      overrun,
  input  logic                      ovr_clr
);

  // Synchroniser and edge detect
  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_prev;
  logic w_fall;

  // FSM
  rx_state_t r_state;
  rx_state_t w_next;
  logic      w_start;
  logic      w_complete;
  logic      w_run;

  // Frame configuration latched at start detection
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] w_prescale_sel;
  logic [3:0]                r_len;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_stp2;

  // Frame datapath
  logic [DATA_WIDTH-1:0] r_shift;
  logic [3:0]            r_bit_cnt;
  logic                  r_par;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_stop_idx;
  logic                  w_frame_stp_err;

  // Sampler interface
  logic w_bit_done;
  logic w_bit_end;
  logic w_sbit;

  // Two-flop synchroniser plus previous value for falling-edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX_IN;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s;
  assign w_run  = (r_state != ST_IDLE);

  // Unsupported ratios fall back to 16x so the counter always has a sane period
  always_comb begin
    w_prescale_sel = PRESCALE_WIDTH'(c_PRESCALE_16);
    if ((Prescale == PRESCALE_WIDTH'(c_PRESCALE_8))  ||
        (Prescale == PRESCALE_WIDTH'(c_PRESCALE_16)) ||
        (Prescale == PRESCALE_WIDTH'(c_PRESCALE_32))) begin
      w_prescale_sel = Prescale;
    end
  end

  uart_rx_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_sampler (
    .clk      (CLK),
    .rst      (RST),
    .start    (w_start),
    .run      (w_run),
    .prescale (r_prescale),
    .rx_s     (r_rx_s),
    .bit_done (w_bit_done),
    .bit_end  (w_bit_end),
    .sbit     (w_sbit)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state: samples arrive on bit_done, bit boundaries on bit_end
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_start = 1'b1;
          w_next  = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_done && w_sbit) begin
          w_next = ST_IDLE;
        end else if (w_bit_end) begin
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_cnt == r_len)) begin
          w_next = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_next = ST_STOP;
        end
      end
      ST_STOP: begin
        // Finish right after the last stop sample so the next start edge,
        // half a bit later, is seen in IDLE
        if (w_bit_done && (!r_stp2 || r_stop_idx)) begin
          w_complete = 1'b1;
          w_next     = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_frame_stp_err = r_stp_err | ~w_sbit;

  // Frame datapath: config latch, data shift, parity and stop accumulation
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prescale <= PRESCALE_WIDTH'(c_PRESCALE_16);
      r_len      <= 4'(DATA_LEN_MIN);
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_stp2     <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par      <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
      r_stop_idx <= 1'b0;
    end else if (w_start) begin
      r_prescale <= w_prescale_sel;
      r_len      <= clamp_len(DATA_LEN, DATA_WIDTH);
      r_par_en   <= PAR_EN;
      r_par_typ  <= PAR_TYP;
      r_stp2     <= STP2;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par      <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
      r_stop_idx <= 1'b0;
    end else begin
      case (r_state)
        ST_DATA: begin
          if (w_bit_done && (r_bit_cnt < r_len)) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (r_bit_cnt == 4'(i)) begin
                r_shift[i] <= w_sbit;
              end
            end
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_par     <= r_par ^ w_sbit;
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_par_err <= ((r_par ^ w_sbit) != r_par_typ);
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_stp_err <= w_frame_stp_err;
          end
          if (w_bit_end) begin
            r_stop_idx <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_complete && (!data_valid || data_ready)) begin
        P_DATA     <= r_shift;
        par_err    <= r_par_err;
        stp_err    <= w_frame_stp_err;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (w_complete && data_valid && !data_ready) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule : uart_rx_ext
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ext
// Description : Self-checking bench for uart_rx_ext; expected frames are
//               queued as they are driven and compared when data_valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ext;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic [3:0] data_len;
  logic       par_en;
  logic       par_typ;
  logic       stp2;
  logic [8:0] p_data;
  logic       data_valid;
  logic       data_ready;
  logic       par_err;
  logic       stp_err;
  logic       overrun;
  logic       ovr_clr;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   n_seen     = 0;
  int   hi_run     = 0;
  int   last_width = 0;

  uart_rx_ext #(
    .DATA_WIDTH     (9),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX_IN      (rx_in),
    .Prescale   (prescale),
    .DATA_LEN   (data_len),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .STP2       (stp2),
    .P_DATA     (p_data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: compare each newly presented frame against the queue head
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && data_valid && !prev_v) begin
        n_seen++;
        if (q.size() == 0) begin
          check("frame_expected", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("p_data", 32'(p_data), 32'(e.data));
          check("par_err", 32'(par_err), 32'(e.pe));
          check("stp_err", 32'(stp_err), 32'(e.se));
        end
      end
      if (data_valid) begin
        hi_run++;
      end else if (hi_run != 0) begin
        last_width = hi_run;
        hi_run     = 0;
      end
      prev_v = data_valid;
    end
  end

  task automatic drive_bit(input logic b, input int presc, input logic glitch);
    for (int c = 0; c < presc; c++) begin
      rx_in = (glitch && (c == presc / 2)) ? 1'b0 : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int len, input int presc,
                            input logic pen, input logic ptyp, input logic s2,
                            input logic bad_par, input logic stop2_val,
                            input int glitch_bit, input logic expect_out);
    exp_t       e;
    logic [8:0] m;
    logic       par;
    m = '0;
    for (int i = 0; i < len; i++) m[i] = d[i];
    par      = (^m) ^ ptyp ^ bad_par;
    prescale = 6'(presc);
    data_len = 4'(len);
    par_en   = pen;
    par_typ  = ptyp;
    stp2     = s2;
    if (expect_out) begin
      e.data = m;
      e.pe   = pen & bad_par;
      e.se   = s2 & ~stop2_val;
      q.push_back(e);
    end
    drive_bit(1'b0, presc, 1'b0);
    // Disturb every config input while the frame is in flight
    prescale = (presc == 16) ? 6'd8 : 6'd16;
    data_len = (len == 8) ? 4'd5 : 4'd8;
    par_en   = ~pen;
    par_typ  = ~ptyp;
    stp2     = ~s2;
    for (int i = 0; i < len; i++) drive_bit(m[i], presc, (glitch_bit == i));
    if (pen) drive_bit(par, presc, 1'b0);
    drive_bit(1'b1, presc, 1'b0);
    if (s2) drive_bit(stop2_val, presc, 1'b0);
    rx_in = 1'b1;
    repeat (2 * presc) @(negedge clk);
    prescale = 6'(presc);
    data_len = 4'(len);
    par_en   = pen;
    par_typ  = ptyp;
    stp2     = s2;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int saved;
    rst        = 1'b1;
    rx_in      = 1'b1;
    prescale   = 6'd16;
    data_len   = 4'd8;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    stp2       = 1'b0;
    data_ready = 1'b1;
    ovr_clr    = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_stp_err", 32'(stp_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5, 16x, even parity, one-cycle valid pulse
    send_frame(9'h0A5, 8, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("drain_a5");
    check("valid_width", 32'(last_width), 32'd1);

    // 5 bits, 8x, second stop bit low
    send_frame(9'h013, 5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    wait_drain("drain_13");

    // 32x odd parity with wrong parity bit, one-cycle low pulse inside bit 2
    send_frame(9'h03C, 8, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1);
    wait_drain("drain_3c");

    // Full 9-bit word, odd parity good
    send_frame(9'h1A5, 9, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("drain_1a5");

    // 6 bits with upper bits masked, two good stop bits
    send_frame(9'h1EA, 6, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("drain_2a");

    // Short idle-line glitch must be rejected, then a normal frame
    prescale = 6'd16;
    data_len = 4'd8;
    par_en   = 1'b0;
    stp2     = 1'b0;
    saved    = n_seen;
    rx_in    = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (64) @(negedge clk);
    check("glitch_no_frame", 32'(n_seen - saved), 32'd0);
    send_frame(9'h055, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("drain_55");

    // Overrun: consumer stalled, second frame dropped
    data_ready = 1'b0;
    send_frame(9'h011, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("drain_11");
    check("ovr_before", 32'(overrun), 32'd0);
    send_frame(9'h022, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    check("ovr_hold_data", 32'(p_data), 32'h011);
    check("ovr_hold_valid", 32'(data_valid), 32'd1);
    check("ovr_set", 32'(overrun), 32'd1);
    repeat (3) @(negedge clk);
    check("ovr_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);
    check("ovr_clr_data", 32'(p_data), 32'h011);
    data_ready = 1'b1;
    @(negedge clk);
    check("accept_clears_valid", 32'(data_valid), 32'd0);

    // Reset in the middle of the data bits, then a clean frame
    prescale = 6'd16;
    data_len = 4'd8;
    drive_bit(1'b0, 16, 1'b0);
    drive_bit(1'b0, 16, 1'b0);
    drive_bit(1'b1, 16, 1'b0);
    drive_bit(1'b0, 8, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_p_data", 32'(p_data), 32'd0);
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    check("mid_rst_par_err", 32'(par_err), 32'd0);
    check("mid_rst_stp_err", 32'(stp_err), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(9'h07E, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("drain_7e");
    check("final_p_data", 32'(p_data), 32'h07E);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_uart_rx_ext
`default_nettype wire

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter DATA_WIDTH, default 9, maximum data bits per frame and width of P_DATA.
REQ-002 Parameter PRESCALE_WIDTH, default 6, width of Prescale; legal Prescale values are 8, 16 and 32.
REQ-003 One clock, CLK; reset RST is synchronous and active-high.
REQ-004 CLK  input  1  oversampling clock, Prescale cycles per bit.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 RX_IN  input  1  asynchronous serial line, idle high.
REQ-007 Prescale  input  PRESCALE_WIDTH  oversampling ratio, sampled at start-bit detection.
REQ-008 DATA_LEN  input  4  data bits per frame, 5..DATA_WIDTH, sampled at start-bit detection.
REQ-009 PAR_EN / PAR_TYP  input  1 each  parity enable; 0 = even, 1 = odd; sampled at start-bit detection.
REQ-010 STP2  input  1  1 = two stop bits required, sampled at start-bit detection.
REQ-011 P_DATA  output  DATA_WIDTH  received word, LSB = first bit, zero-extended above DATA_LEN.
REQ-012 data_valid  output  1  P_DATA/par_err/stp_err hold a frame; data_ready  input  1  consumer accept.
REQ-013 par_err, stp_err  output  1 each  error flags of the held frame; overrun  output  1  sticky lost-frame flag; ovr_clr  input  1  clears overrun.

Function
REQ-014 RX_IN SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
REQ-015 FSM states IDLE, START, DATA, PARITY, STOP, and nothing else.
REQ-016 IDLE->START on a 1->0 transition of rx_s; config inputs are latched in the same cycle.
REQ-017 The edge counter counts 0..Prescale-1 per bit; the bit sample SHALL be the majority of rx_s at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-018 A START sample of 1 is a glitch: return to IDLE, no frame and no flag.
REQ-019 START->DATA after Prescale cycles; DATA shifts DATA_LEN bits, then goes to PARITY if PAR_EN, else to STOP.
REQ-020 Parity error: the XOR of the data bits and the parity bit is not equal to PAR_TYP.
REQ-021 Stop error: any required stop sample is 0 (1 or 2 stop bits per STP2).
REQ-022 The frame completes in the cycle after the final stop-bit sample point (edge count Prescale/2+1); the FSM enters IDLE in that cycle, so a start edge occurring half a bit later is detected.
REQ-023 On completion with data_valid=0, or with data_valid=1 and data_ready=1 in the same cycle: load P_DATA and the flags and set data_valid on the next edge.
REQ-024 On completion with data_valid=1 and data_ready=0: drop the new frame, set overrun, and keep the held frame unchanged.
REQ-025 data_valid clears on data_valid and data_ready with no simultaneous completion; P_DATA and the flags stay stable while data_valid=1.
REQ-026 overrun clears only on ovr_clr; a set from REQ-024 in the same cycle wins.
REQ-027 Config input changes mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-028 RST SHALL force IDLE, clear the counters, and set P_DATA=0, data_valid=0, par_err=0, stp_err=0, overrun=0, and the synchroniser flops to 1.
REQ-029 RST mid-frame SHALL abandon the frame with no output; reception resumes on the first falling edge after RST deasserts.

Structure
REQ-030 The shared package uart_rx_pkg SHALL hold the FSM state encodings, the legal Prescale constants, and DATA_LEN_MIN=5.
REQ-031 A sub-module uart_rx_sampler SHALL hold the edge counter and majority vote and output bit_done/sbit; FSM, shift register and output register stay in the top.

Verification
REQ-032 Prescale=16, DATA_LEN=8, PAR_EN=1, PAR_TYP=0, byte 0xA5 with correct parity, data_ready=1 -> P_DATA=0x0A5, data_valid for 1 cycle, no errors.
REQ-033 Prescale=8, DATA_LEN=5, STP2=1, data 0x13, second stop bit=0 -> P_DATA=0x013, stp_err=1.
REQ-034 Prescale=32, PAR_TYP=1, data 0x3C, parity bit=0 -> par_err=1; single-cycle low pulse mid-bit -> still P_DATA=0x3C.
REQ-035 A 4-cycle low glitch on the idle line at Prescale=16 -> no data_valid; a following frame 0x55 is received correctly.
REQ-036 data_ready=0, frames 0x11 then 0x22 -> P_DATA holds 0x011, overrun=1; ovr_clr -> overrun=0.
REQ-037 RST asserted mid-DATA, then frame 0x7E -> all outputs zero during RST, then P_DATA=0x07E.
